// File: rtl/float_normalizer_if.sv
// Handshake and data bundle between the half-precision adder, the
// normalizer and the downstream consumer. The normalizer takes the slave
// view; the environment driving it takes the master view.
interface float_normalizer_if #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
);
  // Upstream side: raw adder result
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [MANT_W:0]         in_mant;
  logic                    in_carry;
  // Downstream side: normalized half-precision word
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+MANT_W:0]   out_result;
  logic                    out_zero;
  logic                    out_overflow;
  logic                    out_underflow;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
  );
endinterface

// File: rtl/float_normalizer.sv
// Post-adder normalizer for IEEE 754 half precision. Folds the adder
// carry-out into the exponent, then left-shifts one bit per cycle until the
// hidden bit is set, saturating to infinity or flushing to zero at the
// exponent limits. Optional macro FLOAT_NORM_ROUND_EN enables
// round-to-nearest-even on the carry path using the bit shifted out.
module float_normalizer #(
  parameter int EXP_W   = 5,
  parameter int MANT_W  = 10,
  parameter int EXP_MAX = 31
) (
  input logic                 clk,
  input logic                 rst_n,
  float_normalizer_if.slave   bus
);

  localparam int RES_W = 1 + EXP_W + MANT_W;
  // Exponent is carried one bit wider so +1 on carry and -1 on shift never wrap
  localparam logic [EXP_W:0] EXP_LIM = (EXP_W+1)'(EXP_MAX);

  typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [EXP_W:0]     exp_q, exp_d;
  logic [MANT_W:0]    mant_q, mant_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               out_valid_q, out_valid_d;
`ifdef FLOAT_NORM_ROUND_EN
  logic               guard_q, guard_d;
`endif

  logic               round_up;
  logic [MANT_W:0]    frac_r;
  logic [EXP_W:0]     exp_r;
  logic               norm_done;

  // Normalization ends on zero, saturation, hidden bit set, or exponent floor
  assign norm_done = (mant_q == '0) || (exp_q >= EXP_LIM) || mant_q[MANT_W] ||
                     (exp_q <= (EXP_W+1)'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid)
              state_d = (bus.in_exp == EXP_W'(EXP_MAX)) ? OUT : NORM;
      NORM: if (norm_done) state_d = OUT;
      OUT:  if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: load, shift, round and build the result word
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    res_d       = res_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    out_valid_d = out_valid_q;
`ifdef FLOAT_NORM_ROUND_EN
    guard_d     = guard_q;
    // A single guard bit set is always a tie; round to even by bumping odd LSBs
    round_up    = guard_q & mant_q[0];
`else
    round_up    = 1'b0;
`endif
    frac_r = {1'b0, mant_q[MANT_W-1:0]} + (MANT_W+1)'(round_up);
    exp_r  = exp_q + (EXP_W+1)'(frac_r[MANT_W]);

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_sign;
          if (bus.in_carry) begin
            mant_d = {1'b1, bus.in_mant[MANT_W:1]};
            exp_d  = {1'b0, bus.in_exp} + (EXP_W+1)'(1);
`ifdef FLOAT_NORM_ROUND_EN
            guard_d = bus.in_mant[0];
`endif
          end else begin
            mant_d = bus.in_mant;
            exp_d  = {1'b0, bus.in_exp};
`ifdef FLOAT_NORM_ROUND_EN
            guard_d = 1'b0;
`endif
          end
          // Infinity/NaN input bypasses normalization as signed infinity
          if (bus.in_exp == EXP_W'(EXP_MAX)) begin
            res_d = {bus.in_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            ovf_d = 1'b1;
          end
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          res_d  = '0;
          zero_d = 1'b1;
        end else if (exp_q >= EXP_LIM) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (mant_q[MANT_W]) begin
          if (exp_r >= EXP_LIM) begin
            res_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            ovf_d = 1'b1;
          end else begin
            res_d = {sign_q, exp_r[EXP_W-1:0], frac_r[MANT_W-1:0]};
          end
        end else if (exp_q > (EXP_W+1)'(1)) begin
          mant_d = {mant_q[MANT_W-1:0], 1'b0};
          exp_d  = exp_q - (EXP_W+1)'(1);
        end else begin
          // Denormals are not produced: flush to signed zero
          res_d = {sign_q, {(RES_W-1){1'b0}}};
          unf_d = 1'b1;
        end
      end
      OUT: begin
        // out_valid rises one cycle after entering OUT
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          zero_d      = 1'b0;
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so all registers update from pre-edge values.
    if (!rst_n) begin
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef FLOAT_NORM_ROUND_EN
      guard_q     <= 1'b0;
`endif
    end else begin
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
`ifdef FLOAT_NORM_ROUND_EN
      guard_q     <= guard_d;
`endif
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = res_q;
  assign bus.out_zero      = zero_q;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = unf_q;

endmodule

// File: tb/tb_float_normalizer.sv
// Self-checking bench for float_normalizer: directed cases, backpressure,
// mid-operation reset and randomized inputs against a value-level model.
module tb_float_normalizer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  float_normalizer_if #(.EXP_W(5), .MANT_W(10)) bus ();

  float_normalizer #(.EXP_W(5), .MANT_W(10), .EXP_MAX(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: treat the input as an integer significand with an exponent,
  // normalize arithmetically, and count shift cycles for latency.
  task automatic model(input bit s, input int e_in, input int m_in, input bit c,
                       output logic [15:0] res, output logic [2:0] flags, output int lat);
    int e, m, g, frac;
    flags = 3'b000;  // {zero, overflow, underflow}
    if (e_in == 31) begin
      res = {s, 15'h7C00}; flags = 3'b010; lat = 1; return;
    end
    lat = 2;
    if (c) begin
      m = (2048 + m_in) / 2; g = m_in % 2; e = e_in + 1;
    end else begin
      m = m_in; g = 0; e = e_in;
    end
    if (m == 0) begin
      res = 16'h0000; flags = 3'b100; return;
    end
    if (e >= 31) begin
      res = {s, 15'h7C00}; flags = 3'b010; return;
    end
    while (m < 1024 && e > 1) begin
      m = m * 2; e = e - 1; lat++;
    end
    if (m < 1024) begin
      res = {s, 15'h0000}; flags = 3'b001; return;
    end
    frac = m - 1024;
`ifdef FLOAT_NORM_ROUND_EN
    if (g == 1 && (frac % 2) == 1) frac = frac + 1;
    if (frac == 1024) begin frac = 0; e = e + 1; end
`endif
    if (e >= 31) begin
      res = {s, 15'h7C00}; flags = 3'b010; return;
    end
    res = 16'((s ? 32768 : 0) + e * 1024 + frac);
  endtask

  task automatic run_txn(input bit s, input int e, input int m, input bit c, input int hold);
    logic [15:0] er;
    logic [2:0]  ef;
    int          el, lat, waitc;
    model(s, e, m, c, er, ef, el);
    waitc = 0;
    while (!bus.in_ready && waitc < 50) begin @(posedge clk); #1; waitc++; end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e[4:0];
    bus.in_mant  = m[10:0];
    bus.in_carry = c;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), 32'(el));
    check("result", 32'(bus.out_result), 32'(er));
    check("flags", 32'({bus.out_zero, bus.out_overflow, bus.out_underflow}), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result", 32'(bus.out_result), 32'(er));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_flags", 32'({bus.out_zero, bus.out_overflow, bus.out_underflow}), 32'd0);
    check("post_result", 32'(bus.out_result), 32'(er));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.in_carry  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.out_result), 32'd0);
    check("rst_flags", 32'({bus.out_zero, bus.out_overflow, bus.out_underflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_txn(1'b0, 18, 11'b11010000000, 1'b0, 0);  // 8+5 -> 4A80
    check("dir_8p5", 32'(bus.out_result), 32'h4A80);
    run_txn(1'b0, 15, 11'b10000000000, 1'b1, 0);  // 1.5+1.5 -> 4200
    check("dir_carry", 32'(bus.out_result), 32'h4200);
    run_txn(1'b0, 15, 11'b00100000000, 1'b0, 0);  // two shifts -> 3400
    check("dir_shift2", 32'(bus.out_result), 32'h3400);
    run_txn(1'b0, 15, 0, 1'b0, 0);                // zero
    check("dir_zero", 32'(bus.out_result), 32'h0000);
    run_txn(1'b1, 30, 11'b10000000000, 1'b1, 0);  // carry overflow -> FC00
    check("dir_ovf", 32'(bus.out_result), 32'hFC00);
    run_txn(1'b0, 1, 11'b01000000000, 1'b0, 0);   // underflow
    check("dir_unf", 32'(bus.out_result), 32'h0000);
    run_txn(1'b0, 15, 11'b00000000011, 1'b1, 0);  // rounding case
`ifdef FLOAT_NORM_ROUND_EN
    check("dir_round", 32'(bus.out_result), 32'h4002);
`else
    check("dir_round", 32'(bus.out_result), 32'h4001);
`endif
    run_txn(1'b1, 31, 11'b10000000101, 1'b0, 0);  // Inf/NaN input bypass
    run_txn(1'b0, 20, 11'b00000000001, 1'b0, 0);  // worst-case shift count
    run_txn(1'b0, 18, 11'b11010000000, 1'b0, 5);  // backpressure

    // Reset during NORM aborts the operation
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 5'd20;
    bus.in_mant  = 11'b00000000001;
    bus.in_carry = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_result", 32'(bus.out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      check("midrst_no_output", 32'(bus.out_valid), 32'd0);
    end
    run_txn(1'b1, 16, 11'b01100000000, 1'b0, 1);

    // Randomized inputs
    for (int k = 0; k < 40; k++) begin
      bit s, c;
      int e, m;
      s = 1'($urandom_range(0, 1));
      e = int'($urandom_range(0, 31));
      m = int'($urandom_range(0, 2047) >> $urandom_range(0, 11));
      c = ($urandom_range(0, 3) == 0);
      run_txn(s, e, m, c, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_normalizer.md
Name: float_normalizer

Overview:
- Sequential post-adder stage. It sits directly downstream of the half-precision float adder.
- Consumes the adder's raw result: sign, the larger exponent, the 11-bit mantissa magnitude with the hidden bit at bit 10, and the carry-out.
- Produces a normalized IEEE 754 half-precision word (1/5/10).
- Normalizes iteratively with one left shift per cycle, and uses a valid/ready handshake on both sides.

Parameters:
- EXP_W, 5, exponent width.
- MANT_W, 10, stored fraction width (hidden bit excluded).
- EXP_MAX, 31, all-ones exponent (Inf/NaN code).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  block can accept.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  biased exponent of the larger operand.
- in_mant  in  MANT_W+1  mantissa magnitude; bit MANT_W is the hidden-bit position.
- in_carry  in  1  adder carry-out (magnitude >= 2.0).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  16  normalized half-precision word.
- out_zero  out  1  result is zero.
- out_overflow  out  1  result saturated to infinity.
- out_underflow  out  1  result flushed to zero.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1.
  - out_valid=0; out_result=16'h0000.
  - All flags and internal registers 0.
  - Reset asserted mid-operation aborts the operation; no output is produced for the aborted input.
- FSM states: IDLE, NORM, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, register the inputs and go to NORM.
  - Carry handling at load: if in_carry=1, mant={1,in_mant[MANT_W:1]}, guard=in_mant[0], exp=in_exp+1.
  - Input exponent of EXP_MAX: pass through as signed infinity, overflow=1, go directly to OUT.
- NORM (in_ready=0):
  - mant==0: result = sign-cleared +0 (16'h0000), zero=1 → OUT.
  - exp >= EXP_MAX (after carry increment): result {sign,5'h1F,10'h0}, overflow=1 → OUT.
  - mant[MANT_W]==1: result {sign,exp,mant[MANT_W-1:0]} → OUT.
  - mant[MANT_W]==0 and exp>1: mant<<=1 (zero shifted in), exp-=1, stay in NORM.
  - mant[MANT_W]==0 and exp<=1: result {sign,15'h0}, underflow=1 → OUT. Denormals are not produced.
- OUT:
  - out_valid=1; out_result and flags held stable until out_ready=1.
  - On out_valid & out_ready: out_valid=0, flags cleared, go to IDLE. out_result keeps its last value.
  - The next input cannot be accepted in the same cycle; in_ready rises the following cycle.
- Latency (accept edge to out_valid high):
  - Already-normalized or carry input: 2 cycles.
  - Each required left shift adds 1 cycle; worst case 2+MANT_W cycles.
- Exactly one flag (zero/overflow/underflow) or none is set per result.
- Arithmetic: exponent arithmetic is done in EXP_W+1 bits so the carry increment and decrement never wrap.

Optional Feature:
- Macro: FLOAT_NORM_ROUND_EN.
- Defined:
  - Round-to-nearest-even on the carry path, using the guard bit.
  - If guard=1 and fraction LSB=1, increment the fraction (guard=1 with LSB=0 is the tie, left even).
  - Fraction overflow from rounding → fraction 0, exp+1; reaching EXP_MAX → infinity with overflow=1.
  - Adds no cycles; applied in the NORM→OUT transition.
- Undefined: guard bit discarded (truncation). Results are otherwise identical.

Test Plan:
- in_sign=0, in_exp=18, in_mant=11'b11010000000, in_carry=0 (8.0+5.0) → out_result=16'h4A80, out_valid 2 cycles after accept, no flags.
- in_exp=15, in_mant=11'b10000000000, in_carry=1 (1.5+1.5) → 16'h4200, latency 2.
- in_exp=15, in_mant=11'b00100000000, carry=0 → 16'h3400, latency 4. in_mant=0 → 16'h0000 with out_zero=1.
- in_exp=30, in_mant=11'b10000000000, carry=1, sign=1 → 16'hFC00, out_overflow=1. in_exp=1, in_mant=11'b01000000000 → 16'h0000, out_underflow=1.
- in_exp=15, in_mant=11'b00000000011, carry=1 → 16'h4002 with FLOAT_NORM_ROUND_EN, 16'h4001 without.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles → out_valid and out_result stable, in_ready=0 throughout.
  - Pull rst_n low during NORM → out_valid=0, in_ready=1 immediately; a fresh input afterwards completes correctly.
